// File: rtl/logic_arbiter_pkg.sv
// Shared types and constants for the logic-unit arbiter.
// Holds opcode/state enums, flag encodings and the opcode classifier.
package logic_arbiter_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FLAG_W     = 3;

  localparam logic [FLAG_W-1:0] FLAG_EQ = 3'b100;
  localparam logic [FLAG_W-1:0] FLAG_GT = 3'b010;
  localparam logic [FLAG_W-1:0] FLAG_LT = 3'b001;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_NOTA = 4'd5,
    ALU_OP_NOTB = 4'd6,
    ALU_OP_CPR  = 4'd7,
    ALU_OP_SHL  = 4'd8,
    ALU_OP_SHR  = 4'd9
  } enum_alu_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic is_logic_op(enum_alu_opcode_t op);
    logic r;
    r = 1'b0;
    case (op)
      ALU_OP_AND,
      ALU_OP_OR,
      ALU_OP_XOR,
      ALU_OP_NOTA,
      ALU_OP_NOTB,
      ALU_OP_CPR: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_arbiter_if.sv
// Requester/response bundle between the two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface logic_arbiter_if
  import logic_arbiter_pkg::*;
();

  logic                  req0_valid;
  logic                  req0_ready;
  enum_alu_opcode_t      req0_opcode;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  enum_alu_opcode_t      req1_opcode;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [FLAG_W-1:0]     rsp_flag;
  logic                  rsp_err;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_flag, rsp_err
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_data, rsp_flag, rsp_err
  );

endinterface

// File: rtl/logic_arbiter_rr_arb2.sv
// Two-way round-robin grant; pointer register lives in the caller.
// i_ptr picks the winner only when both ports request.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  assign o_gnt_vld = |i_req;
  assign o_gnt_id  = (&i_req) ? i_ptr : i_req[1];

endmodule

// File: rtl/logic_arbiter.sv
// Shares one Logic unit between decode (port 0) and debug (port 1).
// Round-robin grant, registered operands, held response, arch flags.
module logic_arbiter
  import logic_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  logic_arbiter_if.slave        bus,
  output logic [DATA_WIDTH-1:0] lu_a,
  output logic [DATA_WIDTH-1:0] lu_b,
  output enum_alu_opcode_t      lu_opcode,
  input  logic [DATA_WIDTH-1:0] lu_out,
  input  logic [FLAG_W-1:0]     lu_flag,
  output logic [FLAG_W-1:0]     cmp_flags,
  output logic                  busy
);

  arb_state_t            r_state;
  arb_state_t            w_next;
  logic                  r_rr_ptr;
  logic                  r_grant_id;
  logic [DATA_WIDTH-1:0] r_lu_a;
  logic [DATA_WIDTH-1:0] r_lu_b;
  enum_alu_opcode_t      r_lu_op;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [FLAG_W-1:0]     r_rsp_flag;
  logic                  r_rsp_err;
  logic [FLAG_W-1:0]     r_cmp;

  logic                  w_gnt_vld;
  logic                  w_gnt_id;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_rsp_rdy;
  enum_alu_opcode_t      w_sel_op;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;

  rr_arb2 u_rr (
    .i_req     ({bus.req1_valid, bus.req0_valid}),
    .i_ptr     (r_rr_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_sel_op  = w_gnt_id ? bus.req1_opcode : bus.req0_opcode;
  assign w_sel_a   = w_gnt_id ? bus.req1_a : bus.req0_a;
  assign w_sel_b   = w_gnt_id ? bus.req1_b : bus.req0_b;
  assign w_legal   = is_logic_op(w_sel_op);
  assign w_accept  = (r_state == ST_IDLE) && w_gnt_vld;
  assign w_rsp_rdy = r_grant_id ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    busy           = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_gnt_vld && !w_gnt_id;
        bus.req1_ready = w_gnt_vld &&  w_gnt_id;
        if (w_accept)
          w_next = w_legal ? ST_EXEC : ST_RESP;
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        bus.rsp0_valid = !r_grant_id;
        bus.rsp1_valid =  r_grant_id;
        if (w_rsp_rdy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The unit leaves stale flags on logic ops and stale data on CPR;
  // the EXEC capture zeroes whichever field the opcode does not own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_lu_a     <= '0;
      r_lu_b     <= '0;
      r_lu_op    <= ALU_OP_AND;
      r_rsp_data <= '0;
      r_rsp_flag <= '0;
      r_rsp_err  <= 1'b0;
      r_cmp      <= '0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_gnt_id;
        r_rr_ptr   <= ~w_gnt_id;
        if (w_legal) begin
          r_lu_a  <= w_sel_a;
          r_lu_b  <= w_sel_b;
          r_lu_op <= w_sel_op;
        end else begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
          r_rsp_flag <= '0;
        end
      end
      if (r_state == ST_EXEC) begin
        r_rsp_err <= 1'b0;
        if (r_lu_op == ALU_OP_CPR) begin
          r_rsp_flag <= lu_flag;
          r_rsp_data <= '0;
          r_cmp      <= lu_flag;
        end else begin
          r_rsp_flag <= '0;
          r_rsp_data <= lu_out;
        end
      end
    end
  end

  assign lu_a         = r_lu_a;
  assign lu_b         = r_lu_b;
  assign lu_opcode    = r_lu_op;
  assign cmp_flags    = r_cmp;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_flag = r_rsp_flag;
  assign bus.rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: vector table, corner
// sequences and random ops against a behavioural model.
module tb_logic_arbiter;
  import logic_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_arbiter_if bus();

  logic [15:0]      lu_a, lu_b, lu_out;
  enum_alu_opcode_t lu_opcode;
  logic [2:0]       lu_flag, cmp_flags;
  logic             busy;

  logic_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_opcode (lu_opcode),
    .lu_out    (lu_out),
    .lu_flag   (lu_flag),
    .cmp_flags (cmp_flags),
    .busy      (busy)
  );

  // Logic unit stand-in: the field an opcode does not own carries junk
  always_comb begin
    lu_out  = 16'hDEAD;
    lu_flag = 3'b111;
    case (lu_opcode)
      ALU_OP_AND:  lu_out = lu_a & lu_b;
      ALU_OP_OR:   lu_out = lu_a | lu_b;
      ALU_OP_XOR:  lu_out = lu_a ^ lu_b;
      ALU_OP_NOTA: lu_out = ~lu_a;
      ALU_OP_NOTB: lu_out = ~lu_b;
      ALU_OP_CPR:
        lu_flag = (lu_a == lu_b) ? 3'b100 :
                  (lu_a >  lu_b) ? 3'b010 : 3'b001;
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;
  logic [2:0] m_cmp;

  typedef struct {
    int               port;
    enum_alu_opcode_t op;
    logic [15:0]      a;
    logic [15:0]      b;
    int               hold;
    logic [15:0]      ed;
    logic [2:0]       ef;
    logic             ee;
    logic [2:0]       ec;
  } vec_t;

  vec_t tbl[11];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvld(int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic set_req(int p, logic v, enum_alu_opcode_t op,
                         logic [15:0] a, logic [15:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op;
      bus.req0_a = a;     bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op;
      bus.req1_a = a;     bus.req1_b = b;
    end
  endtask

  task automatic set_rsp(int p, logic v);
    if (p == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  function automatic logic m_err(enum_alu_opcode_t op);
    case (op)
      ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
      ALU_OP_NOTA, ALU_OP_NOTB, ALU_OP_CPR: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] m_data(enum_alu_opcode_t op,
                                         logic [15:0] a, logic [15:0] b);
    case (op)
      ALU_OP_AND:  return a & b;
      ALU_OP_OR:   return a | b;
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_NOTA: return 16'hFFFF - a;
      ALU_OP_NOTB: return 16'hFFFF - b;
      default:     return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] m_flag(enum_alu_opcode_t op,
                                        logic [15:0] a, logic [15:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (op != ALU_OP_CPR) return 3'b000;
    if (ia == ib) return FLAG_EQ;
    return (ia > ib) ? FLAG_GT : FLAG_LT;
  endfunction

  task automatic run_op(string tag, int p, enum_alu_opcode_t op,
                        logic [15:0] a, logic [15:0] b, int hold,
                        logic [15:0] ed, logic [2:0] ef,
                        logic ee, logic [2:0] ec);
    logic [15:0] pa, pb;
    enum_alu_opcode_t po;
    int n, lat;
    pa = lu_a; pb = lu_b; po = lu_opcode;
    @(negedge clk);
    set_req(p, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!rdy(p)) begin
      check({tag, " accept timeout"}, 0, 1);
      set_req(p, 1'b0, op, a, b);
      return;
    end
    check({tag, " other ready"}, 32'(rdy(1 - p)), 0);
    @(negedge clk);
    set_req(p, 1'b0, op, a, b);
    #1;
    lat = 1;
    if (ee) begin
      check({tag, " lu_a held"}, 32'(lu_a), 32'(pa));
      check({tag, " lu_b held"}, 32'(lu_b), 32'(pb));
      check({tag, " lu_op held"}, 32'(lu_opcode), 32'(po));
    end else begin
      check({tag, " lu_a"}, 32'(lu_a), 32'(a));
      check({tag, " lu_b"}, 32'(lu_b), 32'(b));
      check({tag, " lu_op"}, 32'(lu_opcode), 32'(op));
    end
    while (!rvld(p) && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), ee ? 1 : 2);
    check({tag, " data"}, 32'(bus.rsp_data), 32'(ed));
    check({tag, " flag"}, 32'(bus.rsp_flag), 32'(ef));
    check({tag, " err"}, 32'(bus.rsp_err), 32'(ee));
    check({tag, " cmp_flags"}, 32'(cmp_flags), 32'(ec));
    check({tag, " other rsp"}, 32'(rvld(1 - p)), 0);
    if (hold > 0) begin
      set_req(0, 1'b1, ALU_OP_AND, 16'h1111, 16'h2222);
      set_req(1, 1'b1, ALU_OP_OR, 16'h3333, 16'h4444);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check({tag, " stall data"}, 32'(bus.rsp_data), 32'(ed));
        check({tag, " stall flag"}, 32'(bus.rsp_flag), 32'(ef));
        check({tag, " stall vld/busy/rdy"},
              {28'd0, rvld(p), busy, bus.req0_ready, bus.req1_ready},
              32'b1100);
      end
      set_req(0, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
      set_req(1, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
    end
    set_rsp(p, 1'b1);
    @(negedge clk); #1;
    check({tag, " back to idle"}, {30'd0, busy, rvld(p)}, 0);
    set_rsp(p, 1'b0);
  endtask

  initial begin
    int grants[$];
    int cur, cyc, mptr;
    vec_t v;
    enum_alu_opcode_t rop;
    logic [15:0] ra, rb;

    tbl[0]  = '{0, ALU_OP_AND,  16'hF0F0, 16'h0FF0, 0, 16'h00F0, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{1, ALU_OP_CPR,  16'h0005, 16'h0003, 1, 16'h0000, 3'b010, 1'b0, 3'b010};
    tbl[2]  = '{1, ALU_OP_CPR,  16'h0007, 16'h0007, 0, 16'h0000, 3'b100, 1'b0, 3'b100};
    tbl[3]  = '{1, ALU_OP_CPR,  16'h0002, 16'h0009, 2, 16'h0000, 3'b001, 1'b0, 3'b001};
    tbl[4]  = '{0, ALU_OP_XOR,  16'h1234, 16'h00FF, 0, 16'h12CB, 3'b000, 1'b0, 3'b001};
    tbl[5]  = '{0, ALU_OP_ADD,  16'h0001, 16'h0002, 6, 16'h0000, 3'b000, 1'b1, 3'b001};
    tbl[6]  = '{1, ALU_OP_OR,   16'hA0A0, 16'h0505, 0, 16'hA5A5, 3'b000, 1'b0, 3'b001};
    tbl[7]  = '{0, ALU_OP_NOTA, 16'h00FF, 16'h1234, 6, 16'hFF00, 3'b000, 1'b0, 3'b001};
    tbl[8]  = '{1, ALU_OP_NOTB, 16'h5555, 16'hFFFF, 1, 16'h0000, 3'b000, 1'b0, 3'b001};
    tbl[9]  = '{1, ALU_OP_SUB,  16'h0008, 16'h0003, 0, 16'h0000, 3'b000, 1'b1, 3'b001};
    tbl[10] = '{0, ALU_OP_CPR,  16'hFFFF, 16'h0000, 0, 16'h0000, 3'b010, 1'b0, 3'b010};

    rst = 1'b1;
    set_req(0, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
    set_req(1, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
    set_rsp(0, 1'b0);
    set_rsp(1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("reset lu_a/lu_b", {lu_a, lu_b}, 0);
    check("reset lu_opcode", 32'(lu_opcode), 32'(ALU_OP_AND));
    check("reset rsp bus",
          {12'd0, bus.rsp_data, bus.rsp_flag, bus.rsp_err}, 0);
    check("reset flags/busy", {28'd0, cmp_flags, busy}, 0);
    check("reset valids",
          {28'd0, bus.req0_ready, bus.req1_ready,
           bus.rsp0_valid, bus.rsp1_valid}, 0);
    rst = 1'b0;
    m_cmp = 3'b000;

    // both requesters together straight out of reset
    @(negedge clk);
    set_req(0, 1'b1, ALU_OP_AND, 16'hFF00, 16'h0FF0);
    set_req(1, 1'b1, ALU_OP_OR,  16'h000F, 16'h00F0);
    set_rsp(0, 1'b1);
    set_rsp(1, 1'b1);
    cur = -1;
    cyc = 0;
    #1;
    while (grants.size() < 3 && cyc < 40) begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("dual single grant",
              32'(bus.req0_ready & bus.req1_ready), 0);
        cur = bus.req1_ready ? 1 : 0;
        grants.push_back(cur);
      end
      if ((bus.rsp0_valid || bus.rsp1_valid) && cur >= 0) begin
        check("dual rsp owner", {30'd0, bus.rsp1_valid, bus.rsp0_valid},
              (cur == 1) ? 2 : 1);
        check("dual rsp data", 32'(bus.rsp_data),
              (cur == 1) ? 32'h00FF : 32'h0F00);
      end
      @(negedge clk); #1; cyc++;
    end
    set_req(0, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
    set_req(1, 1'b0, ALU_OP_AND, 16'h0, 16'h0);
    check("dual grant count", 32'(grants.size()), 3);
    mptr = 0;
    for (int k = 0; k < grants.size(); k++) begin
      check($sformatf("dual grant %0d", k), 32'(grants[k]), 32'(mptr));
      mptr = 1 - mptr;
    end
    cyc = 0;
    while ((busy || bus.rsp0_valid || bus.rsp1_valid) && cyc < 10) begin
      @(negedge clk); #1; cyc++;
    end
    check("dual drain", {30'd0, busy, bus.rsp0_valid | bus.rsp1_valid}, 0);
    set_rsp(0, 1'b0);
    set_rsp(1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      run_op($sformatf("vec%0d", i), v.port, v.op, v.a, v.b, v.hold,
             v.ed, v.ef, v.ee, v.ec);
      m_cmp = v.ec;
    end

    for (int i = 0; i < 40; i++) begin
      rop = enum_alu_opcode_t'(4'($urandom_range(0, 9)));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      if (rop == ALU_OP_CPR) m_cmp = m_flag(rop, ra, rb);
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 1)), rop,
             ra, rb, int'($urandom_range(0, 3)),
             m_data(rop, ra, rb), m_flag(rop, ra, rb), m_err(rop), m_cmp);
    end

    run_op("pre-reset cpr", 0, ALU_OP_CPR, 16'h0033, 16'h0033, 0,
           16'h0000, FLAG_EQ, 1'b0, FLAG_EQ);

    // reset lands while a CPR sits in EXEC
    @(negedge clk);
    set_req(1, 1'b1, ALU_OP_CPR, 16'h0009, 16'h0001);
    #1;
    check("rst-test ready", 32'(bus.req1_ready), 1);
    @(negedge clk);
    set_req(1, 1'b0, ALU_OP_CPR, 16'h0009, 16'h0001);
    #1;
    check("rst-test in exec", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check("rst mid lu", {lu_a, lu_b}, 0);
    check("rst mid opcode", 32'(lu_opcode), 32'(ALU_OP_AND));
    check("rst mid rsp bus",
          {12'd0, bus.rsp_data, bus.rsp_flag, bus.rsp_err}, 0);
    check("rst mid flags/busy", {28'd0, cmp_flags, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_cmp = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("post-rst no rsp",
            {29'd0, bus.rsp0_valid, bus.rsp1_valid, busy}, 0);
    end
    check("post-rst cmp", 32'(cmp_flags), 0);
    run_op("post-rst xor", 1, ALU_OP_XOR, 16'hAAAA, 16'hFFFF, 1,
           16'h5555, 3'b000, 1'b0, m_cmp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
